// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
// State encoding, lock/tick defaults and a run-family helper.
package dac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_RUN,
    S_RD_A,
    S_RD_B,
    S_CAP_B
  } dac_sched_state_e;

  localparam int LOCK_CYC_DEF = 64;
  localparam int MIN_DIV      = 4;

  function automatic logic is_run_family(input dac_sched_state_e s);
    return (s == S_RUN) || (s == S_RD_A) || (s == S_RD_B) || (s == S_CAP_B);
  endfunction

endpackage

// File: rtl/dac_chan_hold.sv
// Per-channel sample holding register: data/valid toward the modulator, sticky overrun
// when a fresh capture lands on a sample the modulator has not yet accepted.
module dac_chan_hold #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_clr_ovr,
  input  logic         i_cap,
  input  logic [W-1:0] i_cap_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_ovr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (i_cap) r_data <= i_cap_data;

      if (i_flush)                 r_valid <= 1'b0;
      else if (i_cap)              r_valid <= 1'b1;
      else if (r_valid && i_ready) r_valid <= 1'b0;

      // Capture with ready in the same cycle is a clean hand-over, not an overrun.
      if (i_clr_ovr)                          r_ovr <= 1'b0;
      else if (i_cap && r_valid && !i_ready)  r_ovr <= 1'b1;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/dac_sample_sched.sv
// Waits for stable PLL lock, then every max(rate_div,4) clocks fetches one table word per
// channel (A then B) from a shared single-port table and hands it to that channel's modulator.
module dac_sample_sched
  import dac_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 8,
  parameter int DIV_W    = 16,
  parameter int LOCK_CYC = LOCK_CYC_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pll_lock,
  input  logic                i_enable,
  input  logic [DIV_W-1:0]    i_rate_div,
  input  logic [ADDR_W-1:0]   i_step_a,
  input  logic [ADDR_W-1:0]   i_step_b,
  output logic                o_tbl_rd,
  output logic [ADDR_W-1:0]   o_tbl_addr,
  input  logic [SAMPLE_W-1:0] i_tbl_data,
  output logic [SAMPLE_W-1:0] o_a_data,
  output logic                o_a_valid,
  input  logic                i_a_ready,
  output logic [SAMPLE_W-1:0] o_b_data,
  output logic                o_b_valid,
  input  logic                i_b_ready,
  output logic                o_running,
  output logic                o_overrun
);

  localparam int              LK_W    = $clog2(LOCK_CYC + 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYC - 1);

  dac_sched_state_e r_state, w_next;
  logic [LK_W-1:0]   r_lock_cnt;
  logic [DIV_W-1:0]  r_tick_cnt;
  logic [ADDR_W-1:0] r_phase_a;
  logic [ADDR_W-1:0] r_phase_b;

  logic [DIV_W-1:0] w_eff_div;
  logic [DIV_W-1:0] w_reload;
  logic             w_run_fam;
  logic             w_lock_lost;
  logic             w_lock_done;
  logic             w_flush;
  logic             w_cap_a;
  logic             w_cap_b;
  logic             w_ovr_a;
  logic             w_ovr_b;

  assign w_eff_div   = (i_rate_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_rate_div;
  assign w_reload    = w_eff_div - DIV_W'(1);
  assign w_run_fam   = is_run_family(r_state);
  assign w_lock_lost = w_run_fam && !i_pll_lock;
  assign w_lock_done = (r_state == S_WAIT_LOCK) && i_pll_lock && (r_lock_cnt == LK_LAST);
  assign w_flush     = !i_enable || w_lock_lost;
  // A capture interrupted by lock loss or disable is dropped, never half-emitted.
  assign w_cap_a     = (r_state == S_RD_B)  && !w_flush;
  assign w_cap_b     = (r_state == S_CAP_B) && !w_flush;

  always_comb begin
    w_next     = r_state;
    o_tbl_rd   = 1'b0;
    o_tbl_addr = '0;
    case (r_state)
      S_IDLE:      if (i_enable) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: if (w_lock_done) w_next = S_RUN;
      S_RUN:       if (r_tick_cnt == '0) w_next = S_RD_A;
      S_RD_A: begin
        o_tbl_rd   = 1'b1;
        o_tbl_addr = r_phase_a;
        w_next     = S_RD_B;
      end
      S_RD_B: begin
        o_tbl_rd   = 1'b1;
        o_tbl_addr = r_phase_b;
        w_next     = S_CAP_B;
      end
      S_CAP_B:     w_next = S_RUN;
      default:     w_next = S_IDLE;
    endcase
    if (w_lock_lost) w_next = S_WAIT_LOCK;
    if (!i_enable)   w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
      r_tick_cnt <= '0;
      r_phase_a  <= '0;
      r_phase_b  <= '0;
    end else begin
      if ((r_state == S_WAIT_LOCK) && i_pll_lock && !w_lock_done)
        r_lock_cnt <= r_lock_cnt + LK_W'(1);
      else
        r_lock_cnt <= '0;

      // Counter keeps running through the fetch states so the tick period stays exact.
      if (w_lock_done)
        r_tick_cnt <= w_reload;
      else if (w_run_fam)
        r_tick_cnt <= (r_tick_cnt == '0) ? w_reload : r_tick_cnt - DIV_W'(1);
      else
        r_tick_cnt <= '0;

      if (w_flush) begin
        r_phase_a <= '0;
        r_phase_b <= '0;
      end else begin
        if (w_cap_a) r_phase_a <= r_phase_a + i_step_a;
        if (w_cap_b) r_phase_b <= r_phase_b + i_step_b;
      end
    end
  end

  dac_chan_hold #(.W(SAMPLE_W)) u_hold_a (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (w_flush),
    .i_clr_ovr  (!i_enable),
    .i_cap      (w_cap_a),
    .i_cap_data (i_tbl_data),
    .i_ready    (i_a_ready),
    .o_data     (o_a_data),
    .o_valid    (o_a_valid),
    .o_overrun  (w_ovr_a)
  );

  dac_chan_hold #(.W(SAMPLE_W)) u_hold_b (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (w_flush),
    .i_clr_ovr  (!i_enable),
    .i_cap      (w_cap_b),
    .i_cap_data (i_tbl_data),
    .i_ready    (i_b_ready),
    .o_data     (o_b_data),
    .o_valid    (o_b_valid),
    .o_overrun  (w_ovr_b)
  );

  assign o_running = w_run_fam;
  assign o_overrun = w_ovr_a || w_ovr_b;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Directed bench for dac_sample_sched: lock qualification, tick timing, phase wrap,
// overrun, lock loss mid-fetch and reset mid-fetch. Table model returns table[i] = i.
module tb_dac_sample_sched;
  import dac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_lock;
  logic        enable;
  logic [15:0] rate_div;
  logic [7:0]  step_a;
  logic [7:0]  step_b;
  logic        tbl_rd;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic        running;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_rd) tbl_data <= {8'h00, tbl_addr};
  end

  dac_sample_sched dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pll_lock (pll_lock),
    .i_enable   (enable),
    .i_rate_div (rate_div),
    .i_step_a   (step_a),
    .i_step_b   (step_b),
    .o_tbl_rd   (tbl_rd),
    .o_tbl_addr (tbl_addr),
    .i_tbl_data (tbl_data),
    .o_a_data   (a_data),
    .o_a_valid  (a_valid),
    .i_a_ready  (a_ready),
    .o_b_data   (b_data),
    .o_b_valid  (b_valid),
    .i_b_ready  (b_ready),
    .o_running  (running),
    .o_overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_running(input string tag, input int exp);
    int n;
    n = 0;
    while (n < 300) begin
      step(1);
      n++;
      if (running) break;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    rst      = 1'b1;
    pll_lock = 1'b0;
    enable   = 1'b0;
    rate_div = 16'd8;
    step_a   = 8'd1;
    step_b   = 8'd3;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    tbl_data = '0;
    step(2);
    chk("rst_state",   32'(dut.r_state), 32'(S_IDLE));
    chk("rst_running", 32'(running), 32'(0));
    chk("rst_tbl_rd",  32'(tbl_rd),  32'(0));
    chk("rst_valids",  32'({a_valid, b_valid}), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    rst    = 1'b0;
    enable = 1'b1;

    // Lock rises at cycle 10, glitches low at count 30, then must see 64 clean cycles.
    step(10);
    chk("wait_lock_state", 32'(dut.r_state), 32'(S_WAIT_LOCK));
    pll_lock = 1'b1;
    step(30);
    chk("no_run_at_30", 32'(running), 32'(0));
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    wait_running("lock_64_after_glitch", 64);

    // rate_div=8, step_a=1, step_b=3: first tick 8 clk after RUN entry.
    step(9);
    chk("a_valid_pre_tick", 32'(a_valid), 32'(0));
    step(1);
    chk("a_valid_0", 32'(a_valid), 32'(1));
    chk("a_data_0",  32'(a_data),  32'(0));
    step(1);
    chk("a_valid_drop", 32'(a_valid), 32'(0));
    chk("b_valid_0",    32'(b_valid), 32'(1));
    chk("b_data_0",     32'(b_data),  32'(0));
    for (int k = 1; k < 4; k++) begin
      step(7);
      chk("a_valid_k", 32'(a_valid), 32'(1));
      chk("a_data_k",  32'(a_data),  32'(k));
      step(1);
      chk("b_valid_k", 32'(b_valid), 32'(1));
      chk("b_data_k",  32'(b_data),  32'(3 * k));
    end

    // Restart with rate_div=1 (clamped to 4) and step_b=FF to exercise wrap.
    enable   = 1'b0;
    rate_div = 16'd1;
    step_b   = 8'hFF;
    step(1);
    chk("idle_after_disable", 32'(dut.r_state), 32'(S_IDLE));
    enable = 1'b1;
    wait_running("relock_from_idle", 65);
    step(6);
    chk("fast_a0", 32'(a_data), 32'(0));
    chk("fast_a0_vld", 32'(a_valid), 32'(1));
    step(1);
    chk("fast_b0", 32'(b_data), 32'(0));
    step(3);
    chk("fast_a1", 32'(a_data), 32'(1));
    chk("fast_a1_vld", 32'(a_valid), 32'(1));
    step(1);
    chk("wrap_b255", 32'(b_data), 32'(255));
    step(3);
    chk("fast_a2", 32'(a_data), 32'(2));
    step(1);
    chk("wrap_b254", 32'(b_data), 32'(254));
    chk("wrap_b254_vld", 32'(b_valid), 32'(1));

    // b_ready low across two ticks: second capture overwrites and flags overrun.
    step(1);
    chk("b_valid_taken", 32'(b_valid), 32'(0));
    b_ready = 1'b0;
    step(3);
    chk("b_hold_253", 32'(b_data), 32'(253));
    chk("no_ovr_first", 32'(overrun), 32'(0));
    step(4);
    chk("b_over_252", 32'(b_data), 32'(252));
    chk("b_over_vld", 32'(b_valid), 32'(1));
    chk("ovr_set", 32'(overrun), 32'(1));
    b_ready = 1'b1;
    step(1);
    chk("b_drain", 32'(b_valid), 32'(0));
    chk("ovr_sticky", 32'(overrun), 32'(1));
    enable = 1'b0;
    step(1);
    chk("ovr_cleared", 32'(overrun), 32'(0));
    chk("disable_running", 32'(running), 32'(0));

    // Lock drop during RD_B.
    rate_div = 16'd8;
    step_b   = 8'd3;
    enable   = 1'b1;
    wait_running("relock_2", 65);
    step(10);
    chk("t5_a0", 32'(a_data), 32'(0));
    step(1);
    chk("t5_b0_vld", 32'(b_valid), 32'(1));
    step(6);
    chk("t5_in_rd_b", 32'(dut.r_state), 32'(S_RD_B));
    chk("t5_addr_b", 32'(tbl_addr), 32'(3));
    pll_lock = 1'b0;
    step(1);
    chk("t5_wait_lock", 32'(dut.r_state), 32'(S_WAIT_LOCK));
    chk("t5_valids", 32'({a_valid, b_valid}), 32'(0));
    chk("t5_tbl_rd", 32'(tbl_rd), 32'(0));
    pll_lock = 1'b1;
    wait_running("relock_after_drop", 64);
    step(10);
    chk("t5_phase_a_restart", 32'(a_data), 32'(0));
    chk("t5_a_vld", 32'(a_valid), 32'(1));
    step(1);
    chk("t5_phase_b_restart", 32'(b_data), 32'(0));
    step(7);
    chk("t5_a1", 32'(a_data), 32'(1));

    // Reset during a fetch.
    step(7);
    chk("t6_in_rd_b", 32'(tbl_rd), 32'(1));
    rst = 1'b1;
    step(1);
    chk("t6_state",   32'(dut.r_state), 32'(S_IDLE));
    chk("t6_running", 32'(running), 32'(0));
    chk("t6_data",    32'({a_data, b_data}), 32'(0));
    chk("t6_valids",  32'({a_valid, b_valid, overrun}), 32'(0));
    chk("t6_tbl",     32'({tbl_rd, tbl_addr}), 32'(0));
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
